conv_last_to_first_with_ready: RTL and testbench
================================================

CONV_LAST_TO_FIRST_WITH_READY -- requirements
Module: conv_last_to_first_with_ready

Interface
REQ-001 SHALL have parameter: width, 8, data bit width (>=1).
REQ-002 SHALL have port: clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: up_valid  input  1  upstream word valid.
REQ-005 SHALL have port: up_ready  output  1  block can accept upstream word.
REQ-006 SHALL have port: up_last  input  1  word is last of its packet.
REQ-007 SHALL have port: up_data  input  width  upstream payload.
REQ-008 SHALL have port: down_valid  output  1  downstream word valid.
REQ-009 SHALL have port: down_ready  input  1  downstream can accept word.
REQ-010 SHALL have port: down_first  output  1  word is first of its packet.
REQ-011 SHALL have port: down_data  output  width  downstream payload.
REQ-012 SHALL have port: pkt_count  output  16  count of packets started downstream.

Function
REQ-013 SHALL define up transfer = up_valid & up_ready; down transfer = down_valid & down_ready.
REQ-014 SHALL hold a start flag, 1 after reset; on each up transfer it takes the value of up_last.
REQ-015 SHALL tag each accepted word with first = start flag value in the cycle of its up transfer.
REQ-016 SHALL store tagged words in a 2-entry FIFO (data + first bit), in order, no loss or duplication.
REQ-017 SHALL drive down_valid, down_first and down_data from FIFO head registers only (no combinational up-to-down path).
REQ-018 SHALL present a word on down_* one cycle after its up transfer if the FIFO was empty (latency 1).
REQ-019 SHALL drive up_ready = (occupancy < 2), from registered state only (no down_ready-to-up_ready path).
REQ-020 SHALL sustain 1 word/cycle when down_ready is held high.
REQ-021 SHALL hold down_data/down_first stable while down_valid=1 and down_ready=0.
REQ-022 SHALL, on simultaneous up and down transfers, keep occupancy unchanged and order preserved.
REQ-023 SHALL ignore up_last/up_data when up_valid=0 or up_ready=0 (start flag unchanged).
REQ-024 SHALL treat a single-word packet (up_last=1 on word after a last) as first=1 for that word.
REQ-025 SHALL drive down_data = 0 and down_first = 0 when down_valid=0.
REQ-026 SHALL, with feature enabled, increment pkt_count by 1 on each down transfer with down_first=1, wrapping 0xFFFF -> 0x0000.

Reset
REQ-027 SHALL, on reset assertion, immediately clear: occupancy 0, down_valid 0, down_first 0, down_data 0, pkt_count 0, start flag 1.
REQ-028 SHALL give up_ready=1 in the first cycle after reset deassertion.
REQ-029 SHALL discard any words in flight when reset asserts mid-packet; next accepted word has first=1.

Configuration
REQ-030 SHALL compile the packet counter only when macro CONV_LAST_TO_FIRST_PKT_CNT_EN is defined.
REQ-031 SHALL, without CONV_LAST_TO_FIRST_PKT_CNT_EN, keep the pkt_count port with constant 0 and no counter register; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, then words A=0x11(last 0), B=0x22(last 0), C=0x33(last 1), D=0x44(last 1), down_ready=1 -> down_first 1,0,0,1; data 11,22,33,44 one cycle delayed; pkt_count ends 2.
REQ-033 SHALL cover: down_ready=0, push 3 words -> up_ready low after 2 accepted, third held; release down_ready -> all three out in order, none lost.
REQ-034 SHALL cover: continuous stream with down_ready toggling 1010... -> output order and first flags match reference model, occupancy never > 2.
REQ-035 SHALL cover: reset asserted mid-packet (after 0x11 last=0) -> outputs clear asynchronously; next word 0x55 emitted with down_first=1.
REQ-036 SHALL cover: 65536 single-word packets with macro defined -> pkt_count wraps to 0x0000; macro undefined -> pkt_count stays 0.

Source files
------------

// File: rtl/conv_last_to_first_with_ready.sv
// ============================================================================
// Module   : conv_last_to_first_with_ready
// Brief    : Converts last-of-packet tagging to first-of-packet tagging through
//            a 2-entry registered FIFO. Optional packet counter is compiled in
//            with macro CONV_LAST_TO_FIRST_PKT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_last_to_first_with_ready #(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_last,
  input  logic [width-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_first,
  output logic [width-1:0] down_data,
  output logic [15:0]      pkt_count
);

  localparam logic [1:0] c_OCC_EMPTY = 2'd0;
  localparam logic [1:0] c_OCC_ONE   = 2'd1;
  localparam logic [1:0] c_OCC_FULL  = 2'd2;

  logic [1:0]       r_count;
  logic             r_start;
  logic [width-1:0] r_head_data;
  logic             r_head_first;
  logic [width-1:0] r_tail_data;
  logic             r_tail_first;

  logic             w_up_xfer;
  logic             w_dn_xfer;

  // Handshake outputs depend only on registered occupancy, never on inputs.
  assign up_ready   = (r_count != c_OCC_FULL);
  assign down_valid = (r_count != c_OCC_EMPTY);
  assign down_data  = r_head_data;
  assign down_first = r_head_first;

  assign w_up_xfer  = up_valid & up_ready;
  assign w_dn_xfer  = down_valid & down_ready;

  // Head registers are zeroed whenever the FIFO drains so idle outputs read 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count      <= c_OCC_EMPTY;
      r_start      <= 1'b1;
      r_head_data  <= '0;
      r_head_first <= 1'b0;
      r_tail_data  <= '0;
      r_tail_first <= 1'b0;
    end else begin
      if (w_up_xfer) begin
        r_start <= up_last;
      end
      case (r_count)
        c_OCC_EMPTY: begin
          if (w_up_xfer) begin
            r_head_data  <= up_data;
            r_head_first <= r_start;
            r_count      <= c_OCC_ONE;
          end
        end
        c_OCC_ONE: begin
          case ({w_up_xfer, w_dn_xfer})
            2'b11: begin
              r_head_data  <= up_data;
              r_head_first <= r_start;
            end
            2'b10: begin
              r_tail_data  <= up_data;
              r_tail_first <= r_start;
              r_count      <= c_OCC_FULL;
            end
            2'b01: begin
              r_head_data  <= '0;
              r_head_first <= 1'b0;
              r_count      <= c_OCC_EMPTY;
            end
            default: begin
            end
          endcase
        end
        c_OCC_FULL: begin
          if (w_dn_xfer) begin
            r_head_data  <= r_tail_data;
            r_head_first <= r_tail_first;
            r_tail_data  <= '0;
            r_tail_first <= 1'b0;
            r_count      <= c_OCC_ONE;
          end
        end
        default: begin
          r_count <= c_OCC_EMPTY;
        end
      endcase
    end
  end

`ifdef CONV_LAST_TO_FIRST_PKT_CNT_EN
  logic [15:0] r_pkt_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pkt_count <= 16'd0;
    end else if (w_dn_xfer && r_head_first) begin
      r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign pkt_count = r_pkt_count;
`else
  assign pkt_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_last_to_first_with_ready.sv
// ============================================================================
// Module   : tb_conv_last_to_first_with_ready
// Brief    : Scoreboard bench for conv_last_to_first_with_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_last_to_first_with_ready;

  localparam int W = 8;
`ifdef CONV_LAST_TO_FIRST_PKT_CNT_EN
  localparam bit PKT_EN = 1'b1;
`else
  localparam bit PKT_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         up_valid = 1'b0;
  logic         up_ready;
  logic         up_last = 1'b0;
  logic [W-1:0] up_data = '0;
  logic         down_valid;
  logic         down_ready = 1'b0;
  logic         down_first;
  logic [W-1:0] down_data;
  logic [15:0]  pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {first, data}, start flag, packet count.
  logic [W:0]   m_q[$];
  bit           m_start = 1'b1;
  logic [15:0]  m_pkt = 16'd0;
  bit           have_prev = 1'b0;
  logic [W:0]   prev_word;

  conv_last_to_first_with_ready #(.width(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_last   (up_last),
    .up_data   (up_data),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_first(down_first),
    .down_data (down_data),
    .pkt_count (pkt_count)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endfunction

  task automatic monitor();
    logic [W:0] w;
    forever begin
      @(negedge clock or posedge reset);
      if (reset) begin
        m_q.delete();
        m_start   = 1'b1;
        m_pkt     = 16'd0;
        have_prev = 1'b0;
        continue;
      end
      check("up_ready", {31'd0, up_ready}, {31'd0, (m_q.size() < 2)});
      check("down_valid", {31'd0, down_valid}, {31'd0, (m_q.size() != 0)});
      check("pkt_count", {16'd0, pkt_count}, PKT_EN ? {16'd0, m_pkt} : 32'd0);
      if (!down_valid) begin
        check("idle_data", {24'd0, down_data}, 32'd0);
        check("idle_first", {31'd0, down_first}, 32'd0);
      end
      if (have_prev && down_valid)
        check("stall_hold", {23'd0, down_first, down_data}, {23'd0, prev_word});
      if (down_valid && down_ready) begin
        if (m_q.size() == 0) begin
          fail_now("underflow");
        end else begin
          w = m_q.pop_front();
          check("down_data", {24'd0, down_data}, {24'd0, w[W-1:0]});
          check("down_first", {31'd0, down_first}, {31'd0, w[W]});
          if (w[W]) m_pkt = m_pkt + 16'd1;
        end
      end
      if (up_valid && up_ready) begin
        m_q.push_back({m_start, up_data});
        m_start = up_last;
      end
      have_prev = down_valid && !down_ready;
      prev_word = {down_first, down_data};
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d, input logic l);
    int n = 0;
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    while (!up_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail_now("push_timeout");
    step();
    up_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("ready_after_reset", {31'd0, up_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    up_valid   = 1'b0;
    down_ready = 1'b1;
    while (m_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    check("drained", m_q.size(), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc;
    fork
      monitor();
    join_none

    // Directed packet A B C | D
    do_reset();
    down_ready = 1'b1;
    push_word(8'h11, 1'b0);
    push_word(8'h22, 1'b0);
    push_word(8'h33, 1'b1);
    push_word(8'h44, 1'b1);
    step();
    step();
    check("pkt_count_two", {16'd0, pkt_count}, PKT_EN ? 32'd2 : 32'd0);
    drain();

    // Backpressure: third word held until downstream releases
    down_ready = 1'b0;
    push_word(8'h61, 1'b0);
    push_word(8'h62, 1'b0);
    check("full_not_ready", {31'd0, up_ready}, 32'd0);
    up_valid = 1'b1;
    up_data  = 8'h63;
    up_last  = 1'b1;
    step();
    step();
    step();
    check("still_full", {31'd0, up_ready}, 32'd0);
    down_ready = 1'b1;
    push_word(8'h63, 1'b1);
    drain();

    // Continuous stream with alternating down_ready, then fully random
    for (int i = 0; i < 400; i++) begin
      up_valid   = 1'b1;
      up_data    = W'($urandom);
      up_last    = ($urandom_range(0, 3) == 0);
      down_ready = (i % 2 == 0);
      step();
    end
    for (int i = 0; i < 400; i++) begin
      up_valid   = $urandom_range(0, 1) == 1;
      up_data    = W'($urandom);
      up_last    = ($urandom_range(0, 2) == 0);
      down_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drain();

    // Reset in the middle of a packet
    down_ready = 1'b0;
    push_word(8'h11, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_down_valid", {31'd0, down_valid}, 32'd0);
    check("rst_down_data", {24'd0, down_data}, 32'd0);
    check("rst_down_first", {31'd0, down_first}, 32'd0);
    check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    step();
    step();
    reset = 1'b0;
    down_ready = 1'b1;
    push_word(8'h55, 1'b0);
    check("post_rst_valid", {31'd0, down_valid}, 32'd1);
    check("post_rst_first", {31'd0, down_first}, 32'd1);
    check("post_rst_data", {24'd0, down_data}, 32'h55);
    drain();

    // 65536 single-word packets: counter wraps back to zero
    do_reset();
    down_ready = 1'b1;
    up_valid   = 1'b1;
    up_last    = 1'b1;
    acc = 0;
    for (int n = 0; n < 70000 && acc < 65536; n++) begin
      up_data = W'($urandom);
      if (up_ready) acc++;
      step();
    end
    if (acc < 65536) fail_now("wrap_stream");
    up_valid = 1'b0;
    step();
    step();
    check("pkt_count_wrap", {16'd0, pkt_count}, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
